// File: rtl/ser_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int SER_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and
// drives it out one bit per clk, with optional forced idle gap between frames.
//
// state | meaning
// IDLE  | waiting for a word, load_ready high
// SHIFT | a frame bit is on sout; counter holds bits remaining after this one
// GAP   | forced idle between frames, load_data ignored
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH      = SER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             xfer;
  logic             last_bit;

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
  assign xfer     = load_valid && load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (xfer) state_d = SHIFT;
      SHIFT: begin
        if (last_bit) begin
          if (xfer)                state_d = SHIFT;
          else if (GAP_CYCLES > 0) state_d = GAP;
          else                     state_d = IDLE;
        end
      end
      GAP:     if (gap_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; a load is shared between IDLE and back-to-back SHIFT.
  always_comb begin
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    sout_d       = sout_q;
    sout_valid_d = 1'b0;
    if (xfer) begin
      shreg_d      = load_data;
      cnt_d        = CNT_LAST;
      sout_d       = lead_bit(load_data);
      sout_valid_d = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (!last_bit) begin
            shreg_d      = shift_word(shreg_q);
            sout_d       = lead_bit(shift_word(shreg_q));
            cnt_d        = cnt_q - 1'b1;
            sout_valid_d = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            gap_d = GAP_LOAD;
          end
        end
        GAP:     if (gap_q != '0) gap_d = gap_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    load_ready = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0));
    busy       = (state_q != IDLE);
    frame_done = last_bit;
    sout       = sout_q;
    sout_valid = sout_valid_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three parameterisations, with a 4-bit
// serial-in shift register model downstream of the MSB-first instance.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // u0: MSB first, no gap; u1: LSB first; u2: MSB first, 2-cycle gap
  logic [3:0] ld0, ld1, ld2;
  logic       lv0, lv1, lv2;
  logic       lr0, lr1, lr2;
  logic       so0, so1, so2;
  logic       sv0, sv1, sv2;
  logic       fd0, fd1, fd2;
  logic       bz0, bz1, bz2;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .load_data(ld0), .load_valid(lv0), .load_ready(lr0),
    .sout(so0), .sout_valid(sv0), .frame_done(fd0), .busy(bz0));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .load_data(ld1), .load_valid(lv1), .load_ready(lr1),
    .sout(so1), .sout_valid(sv1), .frame_done(fd1), .busy(bz1));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .load_data(ld2), .load_valid(lv2), .load_ready(lr2),
    .sout(so2), .sout_valid(sv2), .frame_done(fd2), .busy(bz2));

  // downstream serial-in shift register fed by u0
  logic [3:0] q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 4'h0;
    else     q <= {q[2:0], so0};
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq4;
  logic [7:0] seq8;

  initial begin
    ld0 = 4'h0; ld1 = 4'h0; ld2 = 4'h0;
    lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0;
    #2 rst = 1'b1;
    #5;
    chk("rst_sout", so0, 1'b0);
    chk("rst_sout_valid", sv0, 1'b0);
    chk("rst_frame_done", fd0, 1'b0);
    chk("rst_busy", bz0, 1'b0);
    chk("rst_load_ready", lr0, 1'b1);
    #10 rst = 1'b0;
    tick();

    // MSB first, 1011 -> 1,0,1,1 and downstream Q = 1011 one cycle later
    ld0 = 4'b1011; lv0 = 1'b1;
    tick();
    lv0 = 1'b0;
    seq4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("msb_sout_c%0d", i + 1), so0, seq4[3 - i]);
      chk($sformatf("msb_valid_c%0d", i + 1), sv0, 1'b1);
      chk($sformatf("msb_done_c%0d", i + 1), fd0, (i == 3));
      chk($sformatf("msb_busy_c%0d", i + 1), bz0, 1'b1);
      if (i < 3) chk($sformatf("msb_ready_c%0d", i + 1), lr0, 1'b0);
      tick();
    end
    chk("msb_q_c5", q, 4'b1011);
    chk("msb_valid_c5", sv0, 1'b0);
    chk("msb_busy_c5", bz0, 1'b0);
    chk("msb_sout_hold_c5", so0, 1'b1);

    // LSB first, 1011 -> 1,1,0,1
    ld1 = 4'b1011; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    seq4 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lsb_sout_c%0d", i + 1), so1, seq4[3 - i]);
      chk($sformatf("lsb_done_c%0d", i + 1), fd1, (i == 3));
      tick();
    end
    chk("lsb_valid_c5", sv1, 1'b0);

    // back-to-back A then 5 with valid held
    ld0 = 4'hA; lv0 = 1'b1;
    tick();
    ld0 = 4'h5;
    seq8 = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_sout_c%0d", i + 1), so0, seq8[7 - i]);
      chk($sformatf("b2b_valid_c%0d", i + 1), sv0, 1'b1);
      chk($sformatf("b2b_done_c%0d", i + 1), fd0, (i == 3 || i == 7));
      if (i == 3) chk("b2b_ready_c4", lr0, 1'b1);
      if (i == 4) begin
        chk("b2b_q_c5", q, 4'hA);
        lv0 = 1'b0;
      end
      tick();
    end
    chk("b2b_valid_c9", sv0, 1'b0);
    chk("b2b_q_c9", q, 4'h5);

    // gap of 2: valid held with a new word, not accepted until IDLE
    ld2 = 4'b1011; lv2 = 1'b1;
    tick();
    ld2 = 4'h6;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("gap_ready_c%0d", i + 1), lr2, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("gap_valid_g%0d", i + 1), sv2, 1'b0);
      chk($sformatf("gap_ready_g%0d", i + 1), lr2, 1'b0);
      chk($sformatf("gap_busy_g%0d", i + 1), bz2, 1'b1);
      tick();
    end
    chk("gap_ready_idle", lr2, 1'b1);
    chk("gap_busy_idle", bz2, 1'b0);
    lv2 = 1'b0;
    tick();
    chk("gap_no_accept", bz2, 1'b0);

    // async abort after bit 2 of F
    ld0 = 4'hF; lv0 = 1'b1;
    tick();
    lv0 = 1'b0;
    tick();
    chk("abort_pre_sout", so0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_sout", so0, 1'b0);
    chk("abort_valid", sv0, 1'b0);
    chk("abort_busy", bz0, 1'b0);
    chk("abort_done", fd0, 1'b0);
    tick();
    chk("abort_done_edge", fd0, 1'b0);
    rst = 1'b0;
    tick();
    chk("abort_idle_valid", sv0, 1'b0);
    ld0 = 4'h3; lv0 = 1'b1;
    tick();
    lv0 = 1'b0;
    seq4 = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post_sout_c%0d", i + 1), so0, seq4[3 - i]);
      chk($sformatf("post_done_c%0d", i + 1), fd0, (i == 3));
      tick();
    end
    chk("post_q", q, 4'h3);

    // hygiene: valid pulse while busy and data change mid-frame are ignored
    ld0 = 4'hC; lv0 = 1'b1;
    tick();
    lv0 = 1'b0; ld0 = 4'h0;
    seq4 = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hyg_sout_c%0d", i + 1), so0, seq4[3 - i]);
      if (i == 1) begin ld0 = 4'h9; lv0 = 1'b1; end
      if (i == 2) begin lv0 = 1'b0; ld0 = 4'h0; end
      tick();
    end
    chk("hyg_q", q, 4'hC);
    chk("hyg_valid_after", sv0, 1'b0);
    chk("hyg_busy_after", bz0, 1'b0);
    tick();
    chk("hyg_no_extra", sv0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
